// File: rtl/sd_dma_pkg.sv
// Shared types for the SD DMA burst engine: FSM states, error codes, burst header.
package sd_dma_pkg;

  localparam int unsigned BUS_LEN_W = 9;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    DATA = 3'd2,
    NEXT = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ERR_ALIGN   = 2'b00,
    ERR_TIMEOUT = 2'b01,
    ERR_BUS     = 2'b10,
    ERR_ABORT   = 2'b11
  } err_code_e;

  typedef struct packed {
    logic                 we;
    logic [BUS_LEN_W-1:0] len;
  } burst_hdr_t;

endpackage

// File: rtl/sd_dma_watchdog.sv
// Loadable, clearable idle-cycle counter; expired_o fires on the tick that reaches LIMIT.
module sd_dma_watchdog #(
  parameter int unsigned LIMIT = 4096,
  parameter int unsigned CNT_W = $clog2(LIMIT)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             tick_i,
  output logic             expired_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // Combinational so the engine can leave REQ/DATA on the very cycle the budget runs out.
  assign expired_o = tick_i && (cnt_q == LAST);

endmodule

// File: rtl/sd_dma_burst_engine.sv
// Bus-mastering DMA engine splitting a word transfer into boundary-safe bursts.
// Optional statistics counters are enabled with `define SD_DMA_STATS_EN.
module sd_dma_burst_engine
  import sd_dma_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned BOUNDARY  = 1024,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic                 PCLK_i,
  input  logic                 PRESETn_i,
  input  logic                 start_i,
  input  logic                 dir_i,
  input  logic [ADDR_W-1:0]    base_addr_i,
  input  logic [LEN_W-1:0]     length_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [1:0]           err_code_o,
  output logic                 bus_req_o,
  input  logic                 bus_ack_i,
  output logic [ADDR_W-1:0]    bus_addr_o,
  output logic [BUS_LEN_W-1:0] bus_len_o,
  output logic                 bus_we_o,
  input  logic                 bus_rdy_i,
  input  logic                 bus_err_i,
  output logic [31:0]          bus_wdata_o,
  input  logic [31:0]          bus_rdata_i,
`ifdef SD_DMA_STATS_EN
  output logic [31:0]          beat_cnt_o,
  output logic [31:0]          stall_cnt_o,
`endif
  output logic                 fifo_rd_o,
  input  logic [31:0]          fifo_rdata_i,
  input  logic                 fifo_empty_i,
  output logic                 fifo_wr_o,
  output logic [31:0]          fifo_wdata_o,
  input  logic                 fifo_full_i
);

  localparam int unsigned BOFF_W = $clog2(BOUNDARY);
  localparam int unsigned WD_W   = $clog2(TIMEOUT);

  // Words allowed in the next burst: remaining, MAX_BURST and room left before the boundary.
  function automatic logic [BUS_LEN_W-1:0] burst_len(input logic [BOFF_W-1:2] off,
                                                     input logic [LEN_W-1:0]  rem);
    logic [31:0] room;
    logic [31:0] n;
    room = 32'(BOUNDARY / 4) - 32'(off);
    n    = 32'(MAX_BURST);
    if (room < n)      n = room;
    if (32'(rem) < n)  n = 32'(rem);
    return BUS_LEN_W'(n);
  endfunction

  state_e                 state_q, state_d;
  logic                   dir_q, dir_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [LEN_W-1:0]       rem_q, rem_d;
  logic [BUS_LEN_W-1:0]   beats_q, beats_d;
  logic                   bus_req_q, bus_req_d;
  logic [ADDR_W-1:0]      bus_addr_q, bus_addr_d;
  burst_hdr_t             hdr_q, hdr_d;
  err_code_e              err_code_q, err_code_d;
  logic                   busy_q, done_q, error_q;

  logic active, progress, beat_raw, beat_ok;
  logic abort_hit, bus_hit, tmo_hit, err_any;

  assign active    = (state_q == REQ) || (state_q == DATA);
  assign beat_raw  = (state_q == DATA) && bus_rdy_i && (dir_q ? !fifo_full_i : !fifo_empty_i);
  assign progress  = beat_raw || ((state_q == REQ) && bus_req_q && bus_ack_i);
  assign abort_hit = abort_i && (state_q != IDLE) && (state_q != ERR);
  assign bus_hit   = bus_err_i && active;
  assign err_any   = abort_hit || bus_hit || tmo_hit;
  assign beat_ok   = beat_raw && !err_any;

  sd_dma_watchdog #(.LIMIT(TIMEOUT), .CNT_W(WD_W)) u_watchdog (
    .clk_i      (PCLK_i),
    .rst_ni     (PRESETn_i),
    .clr_i      (progress),
    .load_i     (!active),
    .load_val_i ('0),
    .tick_i     (active && !progress),
    .expired_o  (tmo_hit)
  );

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    beats_d    = beats_q;
    bus_req_d  = bus_req_q;
    bus_addr_d = bus_addr_q;
    hdr_d      = hdr_q;
    err_code_d = err_code_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          dir_d      = dir_i;
          addr_d     = base_addr_i;
          rem_d      = length_i;
          bus_addr_d = base_addr_i;
          beats_d    = burst_len(base_addr_i[BOFF_W-1:2], length_i);
          hdr_d      = '{we: !dir_i, len: burst_len(base_addr_i[BOFF_W-1:2], length_i)};
          // An empty or misaligned job enters REQ without requesting and resolves there.
          bus_req_d  = (length_i != '0) && (base_addr_i[1:0] == 2'b00);
          state_d    = REQ;
        end
      end
      REQ: begin
        if (!bus_req_q) begin
          if (rem_q == '0) begin
            state_d = DONE;
          end else begin
            state_d    = ERR;
            err_code_d = ERR_ALIGN;
          end
        end else if (bus_ack_i) begin
          bus_req_d = 1'b0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (beat_ok) begin
          addr_d  = addr_q + ADDR_W'(4);
          rem_d   = rem_q - LEN_W'(1);
          beats_d = beats_q - BUS_LEN_W'(1);
          if (beats_q == BUS_LEN_W'(1)) state_d = NEXT;
        end
      end
      NEXT: begin
        if (rem_q == '0) begin
          state_d = DONE;
        end else begin
          bus_addr_d = addr_q;
          beats_d    = burst_len(addr_q[BOFF_W-1:2], rem_q);
          hdr_d      = '{we: !dir_q, len: burst_len(addr_q[BOFF_W-1:2], rem_q)};
          bus_req_d  = 1'b1;
          state_d    = REQ;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Error sources override normal sequencing, highest priority last assigned first.
    if (err_any) begin
      state_d   = ERR;
      bus_req_d = 1'b0;
      if (abort_hit)    err_code_d = ERR_ABORT;
      else if (bus_hit) err_code_d = ERR_BUS;
      else              err_code_d = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      state_q    <= IDLE;
      dir_q      <= 1'b0;
      addr_q     <= '0;
      rem_q      <= '0;
      beats_q    <= '0;
      bus_req_q  <= 1'b0;
      bus_addr_q <= '0;
      hdr_q      <= '0;
      err_code_q <= ERR_ALIGN;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      beats_q    <= beats_d;
      bus_req_q  <= bus_req_d;
      bus_addr_q <= bus_addr_d;
      hdr_q      <= hdr_d;
      err_code_q <= err_code_d;
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == DONE);
      error_q    <= (state_d == ERR);
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign error_o    = error_q;
  assign err_code_o = err_code_q;
  assign bus_req_o  = bus_req_q;
  assign bus_addr_o = bus_addr_q;
  assign bus_len_o  = hdr_q.len;
  assign bus_we_o   = hdr_q.we;

  // Beat strobes and data paths follow the bus handshake within the same cycle.
  assign fifo_rd_o    = beat_ok && !dir_q;
  assign fifo_wr_o    = beat_ok && dir_q;
  assign bus_wdata_o  = ((state_q == DATA) && !dir_q) ? fifo_rdata_i : '0;
  assign fifo_wdata_o = ((state_q == DATA) && dir_q)  ? bus_rdata_i  : '0;

`ifdef SD_DMA_STATS_EN
  logic [31:0] beat_cnt_q, stall_cnt_q;
  logic        stall;

  assign stall = (state_q == DATA) && !beat_ok;

  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else if ((state_q == IDLE) && start_i) begin
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (beat_ok && (beat_cnt_q != '1)) beat_cnt_q  <= beat_cnt_q + 32'd1;
      if (stall && (stall_cnt_q != '1))  stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign beat_cnt_o  = beat_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`else
  // Statistics counters are compiled out in this build.
`endif

endmodule

// File: doc/sd_dma_burst_engine.md
SD_DMA_BURST_ENGINE -- requirements
Module: sd_dma_burst_engine

Interface
REQ-001 Parameter ADDR_W, default 32, bus address width in bits.
REQ-002 Parameter LEN_W, default 16, transfer length width, counted in 32-bit words.
REQ-003 Parameter MAX_BURST, default 16, maximum words per burst (power of 2, 1..256).
REQ-004 Parameter BOUNDARY, default 1024, byte boundary no burst may cross (power of 2, at least 4*MAX_BURST).
REQ-005 Parameter TIMEOUT, default 4096, idle cycles allowed without ack or beat.
REQ-006 Ports: PCLK_i in 1 clock; PRESETn_i in 1 reset, asynchronous, active-low.
REQ-007 Ports: start_i in 1 start pulse; dir_i in 1 direction (0 = FIFO to memory, 1 = memory to FIFO); base_addr_i in ADDR_W byte address; length_i in LEN_W word count; abort_i in 1.
REQ-008 Ports: busy_o out 1; done_o out 1 pulse; error_o out 1 pulse; err_code_o out 2 error code.
REQ-009 Ports: bus_req_o out 1; bus_ack_i in 1; bus_addr_o out ADDR_W; bus_len_o out 9 words; bus_we_o out 1; bus_rdy_i in 1; bus_err_i in 1; bus_wdata_o out 32; bus_rdata_i in 32.
REQ-010 Ports: fifo_rd_o out 1; fifo_rdata_i in 32; fifo_empty_i in 1; fifo_wr_o out 1; fifo_wdata_o out 32; fifo_full_i in 1.

Function
REQ-011 The state machine SHALL have the states IDLE, REQ, DATA, NEXT, DONE and ERR.
REQ-012 IDLE: a start_i pulse latches dir_i, base_addr_i and length_i, and the block enters REQ on the next cycle; start_i outside IDLE is ignored.
REQ-013 Start with length_i = 0: the block goes to DONE with no bus_req_o.
REQ-014 Start with base_addr_i[1:0] != 0: the block goes to ERR with err_code_o = 2'b00.
REQ-015 Burst length = min(remaining words, MAX_BURST, (BOUNDARY - addr mod BOUNDARY)/4), computed at REQ entry.
REQ-016 REQ: bus_req_o, bus_addr_o, bus_len_o and bus_we_o = !dir are held stable until bus_ack_i; REQ moves to DATA the cycle after ack.
REQ-017 DATA, dir=0: a beat occurs on a cycle with bus_rdy_i && !fifo_empty_i; fifo_rd_o is asserted that cycle; bus_wdata_o = fifo_rdata_i combinationally.
REQ-018 DATA, dir=1: a beat occurs on a cycle with bus_rdy_i && !fifo_full_i; fifo_wr_o is asserted that cycle; fifo_wdata_o = bus_rdata_i.
REQ-019 On each beat, the address advances by 4 and the remaining count decrements by 1; the last beat of a burst moves to NEXT.
REQ-020 NEXT: remaining = 0 goes to DONE; otherwise back to REQ.
REQ-021 DONE and ERR each last one cycle, pulse done_o or error_o, then return to IDLE; done_o and error_o are never high together.
REQ-022 Watchdog: it counts cycles in REQ/DATA without an ack or beat; reaching TIMEOUT goes to ERR with code 2'b01.
REQ-023 bus_err_i in REQ or DATA goes to ERR with code 2'b10.
REQ-024 abort_i in any non-IDLE state goes to ERR with code 2'b11.
REQ-025 Error priority, when simultaneous: abort, then bus_err, then timeout; any of them takes priority over a beat on the same cycle, and that beat is not counted.
REQ-026 busy_o is high in every state except IDLE.
REQ-027 err_code_o holds its value until the next error.

Reset
REQ-028 PRESETn_i low clears every output to 0, the state to IDLE, and all counters, at any time.
REQ-029 Reset mid-burst produces no done_o or error_o pulse.

Configuration
REQ-030 With SD_DMA_STATS_EN defined, the block adds output beat_cnt_o (32 bits, total beats) and output stall_cnt_o (32 bits, DATA cycles with no beat).
REQ-031 Both counters saturate at their maximum value and clear on start.
REQ-032 Without SD_DMA_STATS_EN, those ports and their logic are absent; all other behaviour is identical.

Structure
REQ-033 Package sd_dma_pkg holds the state enum, the error-code enum (ERR_ALIGN, ERR_TIMEOUT, ERR_BUS, ERR_ABORT) and the bus_len width constant.
REQ-034 Sub-module sd_dma_watchdog is a loadable, clearable timeout counter with a single expiry output.

Verification
REQ-035 dir=0, base 0x1000, len 20, bus_rdy_i always 1 -> bursts of 16@0x1000 and 4@0x1040; 20 fifo_rd_o cycles; one done_o.
REQ-036 dir=1, base 0x13F0, len 8, BOUNDARY 1024 -> bursts of 4@0x13F0 and 4@0x1400; 8 fifo_wr_o cycles.
REQ-037 len 0 -> done_o 2 cycles after start, no bus_req_o; base 0x1002 -> error_o with code 00.
REQ-038 bus_ack_i never asserted, TIMEOUT 64 -> error_o with code 01 at cycle 64 of REQ; busy_o low the following cycle.
REQ-039 abort_i and bus_err_i on the same DATA cycle -> code 11, beat not counted; PRESETn_i low mid-DATA -> all outputs 0, no pulses.
REQ-040 With SD_DMA_STATS_EN, len 4 with bus_rdy_i low for 3 DATA cycles -> beat_cnt_o = 4, stall_cnt_o = 3.
